// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Optional subtract mode is enabled by defining NIBBLE_ADDER_SUB_EN.
package nibble_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of one adder slice step.
   localparam int unsigned NIB_W = 4;

   // Width of the nibble index counter; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned nib);
      return (nib <= 1) ? 1 : $clog2(nib);
   endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// With NIBBLE_ADDER_SUB_EN defined, an extra 'sub' request bit is carried.
interface nibble_serial_adder_if #(
   parameter int unsigned WIDTH = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ovf;
`ifdef NIBBLE_ADDER_SUB_EN
   logic             sub;

   modport master (
      output in_valid, a, b, ci, sub, out_ready,
      input  in_ready, out_valid, s, co, ovf
   );

   modport slave (
      input  in_valid, a, b, ci, sub, out_ready,
      output in_ready, out_valid, s, co, ovf
   );
`else
   modport master (
      output in_valid, a, b, ci, out_ready,
      input  in_ready, out_valid, s, co, ovf
   );

   modport slave (
      input  in_valid, a, b, ci, out_ready,
      output in_ready, out_valid, s, co, ovf
   );
`endif

endinterface

// File: rtl/nibble_serial_adder_add4.sv
// Combinational 4-bit ripple-carry adder slice.
module nibble_add4
   import nibble_adder_pkg::*;
(
   input  logic [NIB_W-1:0] a4,
   input  logic [NIB_W-1:0] b4,
   input  logic             ci,
   output logic [NIB_W-1:0] s4,
   output logic             co
);

   logic c;

   // Bit-by-bit ripple of the carry through the slice.
   always_comb begin
      s4 = '0;
      c  = ci;
      for (int unsigned i = 0; i < NIB_W; i++) begin
         s4[i] = a4[i] ^ b4[i] ^ c;
         c     = (a4[i] & b4[i]) | (c & (a4[i] ^ b4[i]));
      end
      co = c;
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that processes one nibble per clock through a single
// 4-bit slice, holding the inter-nibble carry in a register.
// Define NIBBLE_ADDER_SUB_EN to add a subtract request (bus.sub).
module nibble_serial_adder
   import nibble_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   nibble_serial_adder_if.slave bus
);

   localparam int unsigned NIB   = WIDTH / NIB_W;
   localparam int unsigned IDX_W = idx_width(NIB);

   if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
   end

   state_e             state_q, state_d;
   logic               rdy_q;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic               co_q, co_d;
   logic               ovf_q, ovf_d;

   logic [NIB_W-1:0]   a_nib;
   logic [NIB_W-1:0]   b_nib;
   logic [NIB_W-1:0]   sum_nib;
   logic               co_nib;
   logic               last_nib;
   logic               accept;

   assign a_nib    = a_q[NIB_W*idx_q +: NIB_W];
   assign b_nib    = b_q[NIB_W*idx_q +: NIB_W];
   assign last_nib = (idx_q == IDX_W'(NIB - 1));

   nibble_add4 u_add4 (
      .a4 (a_nib),
      .b4 (b_nib),
      .ci (carry_q),
      .s4 (sum_nib),
      .co (co_nib)
   );

   // in_ready is held low until the first edge after reset is released.
   assign bus.in_ready  = (state_q == IDLE) && rdy_q;
   assign bus.out_valid = (state_q == DONE);
   assign bus.s         = s_q;
   assign bus.co        = co_q;
   assign bus.ovf       = ovf_q;

   assign accept = bus.in_valid && bus.in_ready;

   // Ready-enable flag: comes up on the first clock after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdy_q <= 1'b0;
      else     rdy_q <= 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and datapath next values.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = bus.a;
`ifdef NIBBLE_ADDER_SUB_EN
               // Subtract as a + ~b + 1; ci is ignored in this mode.
               if (bus.sub) begin
                  b_d     = ~bus.b;
                  carry_d = 1'b1;
               end else begin
                  b_d     = bus.b;
                  carry_d = bus.ci;
               end
`else
               b_d     = bus.b;
               carry_d = bus.ci;
`endif
               idx_d   = '0;
               s_d     = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            s_d[NIB_W*idx_q +: NIB_W] = sum_nib;
            carry_d = co_nib;
            idx_d   = idx_q + 1'b1;
            if (last_nib) begin
               co_d    = co_nib;
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (sum_nib[NIB_W-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand, carry, index and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule
